// File: rtl/dma_fifo_drain_ctrl.sv
// Drain controller for the single-clock DMA FIFO.
// Gates producer writes, mirrors the FIFO fill level, requests bus slots in
// bursts of up to BL words once enough data is buffered, and steps the DMA
// word address and the remaining-word count on every granted word.
// All state advances only on clk7_en cycles.
module dma_fifo_drain_ctrl #(
    parameter int FD = 16,  // FIFO depth in words
    parameter int BL = 4,   // maximum burst length in words
    parameter int AW = 20,  // DMA word-address width
    parameter int LW = 14   // transfer-length counter width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk7_en,
    input  logic                  cfg_adr_ld,
    input  logic [AW-1:0]         cfg_adr,
    input  logic                  cfg_len_ld,
    input  logic [LW-1:0]         cfg_len,
    input  logic                  src_wr,
    output logic                  src_full,
    output logic                  fifo_wr_en,
    output logic                  fifo_rd_en,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  dma_req,
    input  logic                  dma_gnt,
    output logic [AW-1:0]         dma_adr,
    output logic [$clog2(FD):0]   level,
    output logic                  busy,
    output logic                  done
);

    localparam int LVW = $clog2(FD) + 1;
    localparam int BW  = $clog2(BL + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [LW-1:0] rem;
    logic [BW-1:0] bsz;
    logic [BW-1:0] bcnt;

    logic          len_arm;
    logic          abort;
    logic [LW-1:0] burst_need;
    logic          data_ready;
    logic          last_word;
    logic          burst_end;

    // A zero length loaded while a transfer is in flight cancels it; this
    // also suppresses any grant arriving in the same cycle.
    assign len_arm    = cfg_len_ld && (cfg_len != '0);
    assign abort      = cfg_len_ld && (cfg_len == '0) &&
                        ((state == S_WAIT) || (state == S_BURST));

    assign src_full   = fifo_full;
    assign fifo_wr_en = clk7_en & src_wr & ~fifo_full & ~rst;
    assign fifo_rd_en = clk7_en & (state == S_BURST) & dma_gnt & ~abort & ~rst;

    // A burst only starts once every word it will move is already buffered,
    // so reads can never run ahead of the FIFO contents.
    assign burst_need = (rem > LW'(BL)) ? LW'(BL) : rem;
    assign data_ready = (LW'(level) >= burst_need);
    assign last_word  = (rem == LW'(1));
    assign burst_end  = ((bcnt + BW'(1)) == bsz);

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Next-state selection; only consumed on enabled cycles.
    always_comb begin
        // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (len_arm)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (data_ready)
                    state_nxt = S_BURST;
            end
            S_BURST: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (dma_gnt) begin
                    if (last_word)
                        state_nxt = S_DONE;
                    else if (burst_end)
                        state_nxt = S_WAIT;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM, registered bus request, address and transfer/burst counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= S_IDLE;
            dma_req <= 1'b0;
            dma_adr <= '0;
            rem     <= '0;
            bsz     <= '0;
            bcnt    <= '0;
        end else if (clk7_en) begin
            state   <= state_nxt;
            dma_req <= (state_nxt == S_BURST);
            case (state)
                S_IDLE: begin
                    if (cfg_adr_ld)
                        dma_adr <= cfg_adr;
                    if (len_arm)
                        rem <= cfg_len;
                end
                S_WAIT: begin
                    if (abort)
                        rem <= '0;
                    else if (data_ready) begin
                        bsz  <= BW'(burst_need);
                        bcnt <= '0;
                    end
                end
                S_BURST: begin
                    if (abort)
                        rem <= '0;
                    else if (dma_gnt) begin
                        dma_adr <= dma_adr + AW'(1);
                        rem     <= rem - LW'(1);
                        bcnt    <= bcnt + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Mirror of the FIFO occupancy, saturating at 0 and FD.
    always_ff @(posedge clk) begin
        if (rst)
            level <= '0;
        else begin
            case ({fifo_wr_en, fifo_rd_en})
                2'b10:   if (level != LVW'(FD)) level <= level + LVW'(1);
                2'b01:   if (level != '0)       level <= level - LVW'(1);
                default: ;
            endcase
        end
    end

    // The mirrored level must agree with the FIFO's own empty flag.
    level_tracks_empty: assert property (
        @(posedge clk) disable iff (rst) ((level == '0) == fifo_empty)
    );

endmodule

// File: tb/tb_dma_fifo_drain_ctrl.sv
// Self-checking bench for dma_fifo_drain_ctrl.
// A transfer-level reference model (armed flag, words left in the burst,
// remaining count, address, FIFO occupancy) predicts every output each
// cycle; it also stands in for the FIFO by driving fifo_full/fifo_empty.
module tb_dma_fifo_drain_ctrl;

    localparam int FD = 16;
    localparam int BL = 4;
    localparam int AW = 20;
    localparam int LW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk7_en = 1'b0;
    logic          cfg_adr_ld = 1'b0;
    logic [AW-1:0] cfg_adr = '0;
    logic          cfg_len_ld = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic          src_wr = 1'b0;
    logic          fifo_full = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          dma_gnt = 1'b0;

    logic          src_full;
    logic          fifo_wr_en;
    logic          fifo_rd_en;
    logic          dma_req;
    logic [AW-1:0] dma_adr;
    logic [$clog2(FD):0] level;
    logic          busy;
    logic          done;

    dma_fifo_drain_ctrl #(.FD(FD), .BL(BL), .AW(AW), .LW(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk7_en    (clk7_en),
        .cfg_adr_ld (cfg_adr_ld),
        .cfg_adr    (cfg_adr),
        .cfg_len_ld (cfg_len_ld),
        .cfg_len    (cfg_len),
        .src_wr     (src_wr),
        .src_full   (src_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_rd_en (fifo_rd_en),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .dma_req    (dma_req),
        .dma_gnt    (dma_gnt),
        .dma_adr    (dma_adr),
        .level      (level),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_level, m_rem, m_left, m_adr;
    bit m_armed, m_done;

    int checks = 0;
    int errors = 0;

    // Observation bookkeeping for scenario checks
    int   n_rd, n_wr, n_done;
    logic prev_done = 1'b0;
    int   rd_adrs[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_rd = 0;
        n_wr = 0;
        n_done = 0;
        rd_adrs.delete();
    endtask

    // One clock: compare on the falling edge, then advance the model.
    task automatic tick();
        bit exp_wr, exp_rd, abort_c;
        int lvl_old, need;
        @(negedge clk);
        abort_c = cfg_len_ld && (cfg_len == '0) && m_armed;
        exp_wr  = clk7_en && src_wr && (m_level != FD) && !rst;
        exp_rd  = clk7_en && !rst && (m_left > 0) && dma_gnt && !abort_c;
        check("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        check("dma_req",    32'(dma_req),    32'(m_left > 0));
        check("busy",       32'(busy),       32'(m_armed || m_done));
        check("done",       32'(done),       32'(m_done));
        check("dma_adr",    32'(dma_adr),    32'(m_adr));
        check("level",      32'(level),      32'(m_level));
        check("src_full",   32'(src_full),   32'(m_level == FD));
        check("level_vs_empty", 32'(level == '0), 32'(fifo_empty));
        if (fifo_rd_en === 1'b1) begin
            n_rd++;
            rd_adrs.push_back(int'(dma_adr));
        end
        if (fifo_wr_en === 1'b1) n_wr++;
        if (done === 1'b1 && prev_done !== 1'b1) n_done++;
        prev_done = done;

        @(posedge clk);
        if (rst) begin
            m_level = 0; m_rem = 0; m_left = 0; m_adr = 0;
            m_armed = 0; m_done = 0;
        end else if (clk7_en) begin
            lvl_old = m_level;
            m_level = m_level + int'(exp_wr) - int'(exp_rd);
            if (m_level > FD) m_level = FD;
            if (m_level < 0)  m_level = 0;
            if (m_done) begin
                m_done = 0;
            end else if (!m_armed) begin
                if (cfg_adr_ld) m_adr = int'(cfg_adr);
                if (cfg_len_ld && cfg_len != '0) begin
                    m_armed = 1;
                    m_rem   = int'(cfg_len);
                    m_left  = 0;
                end
            end else if (abort_c) begin
                m_armed = 0; m_left = 0; m_rem = 0;
            end else if (m_left == 0) begin
                need = (m_rem < BL) ? m_rem : BL;
                if (lvl_old >= need) m_left = need;
            end else if (dma_gnt) begin
                m_adr  = (m_adr + 1) % (1 << AW);
                m_rem  = m_rem - 1;
                m_left = m_left - 1;
                if (m_rem == 0) begin
                    m_armed = 0; m_left = 0; m_done = 1;
                end
            end
        end
        #1;
        fifo_full  = (m_level == FD);
        fifo_empty = (m_level == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clk7_en = 1'b0;
        src_wr = 1'b0; dma_gnt = 1'b0; cfg_adr_ld = 1'b0; cfg_len_ld = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clk7_en = 1'b1;
    endtask

    task automatic load_adr(input logic [AW-1:0] a);
        cfg_adr = a; cfg_adr_ld = 1'b1;
        tick();
        cfg_adr_ld = 1'b0;
    endtask

    task automatic load_len(input logic [LW-1:0] n);
        cfg_len = n; cfg_len_ld = 1'b1;
        tick();
        cfg_len_ld = 1'b0;
    endtask

    task automatic write_words(input int n);
        src_wr = 1'b1;
        for (int i = 0; i < n; i++) tick();
        src_wr = 1'b0;
    endtask

    // Bounded wait for the model to return to idle; an expired bound fails.
    task automatic run_until_idle(input string tag, input int max_cycles);
        int i;
        i = 0;
        while ((m_armed || m_done) && i < max_cycles) begin
            tick();
            i++;
        end
        check({tag, "_timeout"}, 32'(m_armed || m_done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        m_level = 0; m_rem = 0; m_left = 0; m_adr = 0;
        m_armed = 0; m_done = 0;
        clear_counts();
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        check("reset_busy",  32'(busy),    32'd0);
        check("reset_req",   32'(dma_req), 32'd0);
        check("reset_done",  32'(done),    32'd0);
        check("reset_adr",   32'(dma_adr), 32'd0);
        check("reset_level", 32'(level),   32'd0);

        // Prefill and single transfer: two 4-word bursts from 0x100
        clear_counts();
        load_adr(20'h00100);
        write_words(8);
        check("prefill_level", 32'(level), 32'd8);
        load_len(14'd8);
        dma_gnt = 1'b1;
        run_until_idle("prefill", 40);
        dma_gnt = 1'b0;
        tick();
        check("prefill_reads", 32'(n_rd),    32'd8);
        check("prefill_dones", 32'(n_done),  32'd1);
        check("prefill_adr",   32'(dma_adr), 32'h108);
        check("prefill_level_end", 32'(level), 32'd0);
        check("prefill_first_adr", 32'(rd_adrs[0]), 32'h100);
        check("prefill_last_adr",  32'(rd_adrs[7]), 32'h107);

        // Tail burst: 4 then 2; second burst waits for two words
        do_reset();
        clear_counts();
        load_len(14'd6);
        write_words(4);
        dma_gnt = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("tail_first_reads", 32'(n_rd), 32'd4);
        write_words(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("tail_wait_req", 32'(dma_req), 32'd0);
        end
        write_words(1);
        run_until_idle("tail", 20);
        dma_gnt = 1'b0;
        tick();
        check("tail_reads", 32'(n_rd),   32'd6);
        check("tail_dones", 32'(n_done), 32'd1);

        // Starvation: 3 words then a long pause
        do_reset();
        clear_counts();
        load_len(14'd4);
        dma_gnt = 1'b1;
        write_words(3);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("starve_req", 32'(dma_req),    32'd0);
            check("starve_rd",  32'(fifo_rd_en), 32'd0);
        end
        write_words(1);
        run_until_idle("starve", 20);
        dma_gnt = 1'b0;
        tick();
        check("starve_reads", 32'(n_rd), 32'd4);

        // Full FIFO: saturation, back-pressure, read at full
        do_reset();
        clear_counts();
        write_words(20);
        check("full_writes",   32'(n_wr),     32'd16);
        check("full_level",    32'(level),    32'd16);
        check("full_src_full", 32'(src_full), 32'd1);
        load_len(14'd3);
        tick();
        src_wr = 1'b1; dma_gnt = 1'b1;
        tick();
        check("full_rd_level", 32'(level), 32'd15);
        tick();
        check("full_wr_rd_level", 32'(level), 32'd15);
        src_wr = 1'b0;
        tick();
        check("full_drain_level", 32'(level), 32'd14);
        run_until_idle("full", 10);
        dma_gnt = 1'b0;

        // Abort in the same cycle as the second grant
        do_reset();
        clear_counts();
        write_words(8);
        load_len(14'd8);
        tick();
        dma_gnt = 1'b1;
        tick();
        cfg_len = '0; cfg_len_ld = 1'b1;
        tick();
        cfg_len_ld = 1'b0; dma_gnt = 1'b0;
        tick();
        tick();
        check("abort_reads", 32'(n_rd),    32'd1);
        check("abort_dones", 32'(n_done),  32'd0);
        check("abort_busy",  32'(busy),    32'd0);
        check("abort_req",   32'(dma_req), 32'd0);
        check("abort_level", 32'(level),   32'd7);

        // Reset in the middle of a burst
        do_reset();
        clear_counts();
        write_words(4);
        load_len(14'd4);
        tick();
        dma_gnt = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        dma_gnt = 1'b0;
        check("rst_mid_reads", 32'(n_rd),    32'd1);
        check("rst_mid_req",   32'(dma_req), 32'd0);

        // Address wrap with a 1-in-4 clock enable
        do_reset();
        clear_counts();
        write_words(4);
        load_adr(20'hFFFFE);
        load_len(14'd4);
        dma_gnt = 1'b1;
        for (int i = 0; i < 200 && (m_armed || m_done); i++) begin
            clk7_en = ((i % 4) == 0);
            tick();
        end
        clk7_en = 1'b1;
        dma_gnt = 1'b0;
        check("wrap_idle",  32'(m_armed || m_done), 32'd0);
        check("wrap_reads", 32'(n_rd), 32'd4);
        if (rd_adrs.size() == 4) begin
            check("wrap_adr0", 32'(rd_adrs[0]), 32'hFFFFE);
            check("wrap_adr1", 32'(rd_adrs[1]), 32'hFFFFF);
            check("wrap_adr2", 32'(rd_adrs[2]), 32'h00000);
            check("wrap_adr3", 32'(rd_adrs[3]), 32'h00001);
        end
        check("wrap_final_adr", 32'(dma_adr), 32'h00002);

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 149) == 0);
            clk7_en    = ($urandom_range(0, 3) != 0);
            src_wr     = ($urandom_range(0, 1) == 1);
            dma_gnt    = ($urandom_range(0, 2) != 0);
            cfg_adr_ld = ($urandom_range(0, 15) == 0);
            cfg_adr    = AW'($urandom());
            cfg_len_ld = ($urandom_range(0, 11) == 0);
            cfg_len    = LW'($urandom_range(0, 10));
            tick();
        end
        rst = 1'b0; clk7_en = 1'b1; cfg_adr_ld = 1'b0; cfg_len_ld = 1'b0;
        src_wr = 1'b1; dma_gnt = 1'b1;
        run_until_idle("random", 200);
        src_wr = 1'b0; dma_gnt = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
